// File: rtl/multi_port_accumulator.sv
// N-channel combiner: each accepted beat is reduced to a channel sum, optionally
// accumulated into a running total, and queued in a DEPTH-entry result FIFO.
module multi_port_accumulator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned RW      = WIDTH + $clog2(CHANNELS),
    localparam int unsigned CW      = $clog2(DEPTH + 1),
    localparam int unsigned PW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic                      mode_in,
    input  logic                      clear_in,
    output logic [RW-1:0]             result_out,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [CW-1:0]             count_out,
    output logic                      overflow_out
);

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [RW-1:0] acc;
    logic          ovf;

    logic [RW-1:0] sum;
    logic [RW:0]   acc_sum;
    logic          push;
    logic          pop;
    logic [RW-1:0] push_val;
    logic [RW-1:0] acc_next;
    logic          ovf_next;

    // Channel reduction at RW bits, wide enough that it can never wrap.
    always_comb begin
        sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum = sum + RW'(data_in[c*WIDTH +: WIDTH]);
        end
    end

    assign acc_sum = {1'b0, acc} + {1'b0, sum};
    assign push    = valid_in && ready_out;
    assign pop     = result_valid && result_ready;

    // Accumulator update; a clear colliding with a mode-1 beat restarts from the beat's sum.
    always_comb begin
        push_val = sum;
        acc_next = acc;
        ovf_next = ovf;
        if (push) begin
            if (mode_in) begin
                if (clear_in) begin
                    acc_next = sum;
                    ovf_next = 1'b0;
                end else begin
                    acc_next = acc_sum[RW-1:0];
                    push_val = acc_sum[RW-1:0];
                    if (acc_sum[RW]) begin
                        ovf_next = 1'b1;
                    end
                end
            end else if (clear_in) begin
                acc_next = '0;
                ovf_next = 1'b0;
            end
        end else if (clear_in) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_next;
            ovf <= ovf_next;
        end
    end

    // Result FIFO; DEPTH is a power of two so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_val;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign ready_out    = (count < CW'(DEPTH));
    assign result_valid = (count != '0);
    assign result_out   = mem[rd_ptr];
    assign count_out    = count;
    assign overflow_out = ovf;

endmodule

// File: tb/tb_multi_port_accumulator.sv
// Directed bench for multi_port_accumulator with a queue-based result scoreboard.
module tb_multi_port_accumulator;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        mode_in;
    logic        clear_in;
    logic [8:0]  result_out;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  count_out;
    logic        overflow_out;

    int          checks;
    int          errors;
    logic [8:0]  exp_q[$];
    logic [8:0]  acc_m;
    logic        ovf_m;

    multi_port_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .mode_in      (mode_in),
        .clear_in     (clear_in),
        .result_out   (result_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .count_out    (count_out),
        .overflow_out (overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard pop side: compare the FIFO head whenever a pop is about to happen.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result_out), 32'h1ff);
            end else begin
                check("result", 32'(result_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drive one beat from posedge+1, wait for acceptance, push its expected result.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic mode, input logic clr);
        int         n;
        logic [8:0] s;
        logic [9:0] t;
        logic [8:0] v;
        data_in  = {b, a};
        mode_in  = mode;
        clear_in = clr;
        valid_in = 1'b1;
        n = 0;
        while (!ready_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            check("accept_timeout", 32'(ready_out), 32'd1);
        end else begin
            s = 9'(a) + 9'(b);
            v = s;
            if (mode) begin
                if (clr) begin
                    acc_m = s;
                    ovf_m = 1'b0;
                end else begin
                    t = {1'b0, acc_m} + {1'b0, s};
                    acc_m = t[8:0];
                    v = t[8:0];
                    if (t[9]) ovf_m = 1'b1;
                end
            end else if (clr) begin
                acc_m = '0;
                ovf_m = 1'b0;
            end
            exp_q.push_back(v);
        end
        @(posedge clk); #1;
        clear_in = 1'b0;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        clear_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        result_ready = 1'b1;
        n = 0;
        while (count_out != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_count", 32'(count_out), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        acc_m = '0; ovf_m = 1'b0;
        rst = 1'b1; data_in = '0; valid_in = 1'b0; mode_in = 1'b0;
        clear_in = 1'b0; result_ready = 1'b0;
        #12;
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result_out), 32'd0);
        check("rst_ovf", 32'(overflow_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", 32'(result_valid), 32'd0);
        check("idle_count", 32'(count_out), 32'd0);

        // Pass mode: 200 + 100.
        result_ready = 1'b1;
        send(8'd200, 8'd100, 1'b0, 1'b0);
        check("pass_valid", 32'(result_valid), 32'd1);
        check("pass_count", 32'(count_out), 32'd1);
        check("pass_value", 32'(result_out), 32'd300);
        idle();
        check("pass_popped", 32'(count_out), 32'd0);

        // Accumulate 510 three times: 510, 508, 506 with overflow from the second.
        send(8'd255, 8'd255, 1'b1, 1'b0);
        check("acc1_ovf", 32'(overflow_out), 32'd0);
        send(8'd255, 8'd255, 1'b1, 1'b0);
        check("acc2_ovf", 32'(overflow_out), 32'd1);
        send(8'd255, 8'd255, 1'b1, 1'b0);
        check("acc3_ovf", 32'(overflow_out), 32'd1);
        check("acc3_model", 32'(acc_m), 32'd506);
        // 506 + 106 wraps to 100 with overflow still set.
        send(8'd100, 8'd6, 1'b1, 1'b0);
        check("acc100_ovf", 32'(overflow_out), 32'd1);

        // Clear colliding with a mode-1 beat: push 7, acc 7, overflow cleared.
        send(8'd3, 8'd4, 1'b1, 1'b1);
        check("clr_ovf", 32'(overflow_out), 32'd0);
        check("clr_result", 32'(result_out), 32'd7);
        send(8'd0, 8'd0, 1'b1, 1'b0);
        check("clr_acc", 32'(result_out), 32'd7);
        idle();
        drain();

        // Back-pressure: fill four entries, the fifth beat is held until one pop.
        result_ready = 1'b0;
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd3, 8'd4, 1'b0, 1'b0);
        send(8'd5, 8'd6, 1'b0, 1'b0);
        send(8'd7, 8'd8, 1'b0, 1'b0);
        check("full_count", 32'(count_out), 32'd4);
        check("full_ready", 32'(ready_out), 32'd0);
        data_in = {8'd10, 8'd9}; mode_in = 1'b0; valid_in = 1'b1;
        @(posedge clk); #1;
        check("held_count", 32'(count_out), 32'd4);
        check("held_ready", 32'(ready_out), 32'd0);
        check("held_head", 32'(result_out), 32'd3);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("pop_ready", 32'(ready_out), 32'd1);
        check("pop_count", 32'(count_out), 32'd3);
        send(8'd9, 8'd10, 1'b0, 1'b0);
        check("wrap_count", 32'(count_out), 32'd4);
        idle();
        drain();

        // Reset mid-operation discards queued entries and the accumulator.
        result_ready = 1'b0;
        send(8'd50, 8'd50, 1'b1, 1'b0);
        send(8'd50, 8'd50, 1'b1, 1'b0);
        send(8'd50, 8'd50, 1'b1, 1'b0);
        idle();
        check("pre_rst_count", 32'(count_out), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count_out), 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_ready", 32'(ready_out), 32'd1);
        exp_q.delete();
        acc_m = '0; ovf_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        result_ready = 1'b1;
        send(8'd1, 8'd2, 1'b1, 1'b0);
        check("post_rst_result", 32'(result_out), 32'd3);
        idle();

        // Clear without a beat zeroes the running total and the flag.
        send(8'd255, 8'd255, 1'b1, 1'b0);
        send(8'd255, 8'd255, 1'b1, 1'b0);
        check("ovf_again", 32'(overflow_out), 32'd1);
        valid_in = 1'b0; clear_in = 1'b1;
        acc_m = '0; ovf_m = 1'b0;
        @(posedge clk); #1;
        clear_in = 1'b0;
        check("clear_only_ovf", 32'(overflow_out), 32'd0);
        send(8'd5, 8'd0, 1'b1, 1'b0);
        check("clear_only_acc", 32'(result_out), 32'd5);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
